// File: rtl/projectile_engine.sv
// projectile_engine: flies one projectile per turn with gravity, signed wind,
// wall/ground/off-screen collision, direct/splash damage and a sticky game-over.
module projectile_engine #(
  parameter int TICK_DIV   = 500000,
  parameter int XW         = 12,
  parameter int HP_INIT    = 100,
  parameter int DMG_DIRECT = 30,
  parameter int DMG_SPLASH = 10,
  parameter int X_LAUNCH1  = 262,
  parameter int X_LAUNCH2  = 712,
  parameter int Y_LAUNCH   = 420,
  parameter int GROUND_Y   = 455,
  parameter int WALL_XL    = 497,
  parameter int WALL_XR    = 527,
  parameter int WALL_Y     = 384,
  parameter int SCREEN_W   = 1024,
  parameter int ZONE1_L    = 112,
  parameter int ZONE2_L    = 712,
  parameter int GRAVITY    = 1,
  parameter int X_PARK     = 1025,
  parameter int Y_PARK     = 768
) (
  input  logic          clk60MHz,
  input  logic          rst,
  input  logic          throw_start,
  input  logic          turn,
  input  logic [4:0]    speed,
  input  logic [5:0]    vy_init,
  input  logic [3:0]    wind,
  output logic [XW-1:0] xpos_particle,
  output logic [XW-1:0] ypos_particle,
  output logic [6:0]    hp_player1,
  output logic [6:0]    hp_player2,
  output logic          busy,
  output logic          end_throw,
  output logic [1:0]    hit_code,
  output logic          game_over
);

  localparam int IW = XW + 2;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  typedef logic signed [IW-1:0] pos_t;

  localparam pos_t P_ZERO     = '0;
  localparam pos_t P_X_L1     = pos_t'(X_LAUNCH1);
  localparam pos_t P_X_L2     = pos_t'(X_LAUNCH2);
  localparam pos_t P_Y_L      = pos_t'(Y_LAUNCH);
  localparam pos_t P_GROUND   = pos_t'(GROUND_Y);
  localparam pos_t P_WALL_XL  = pos_t'(WALL_XL);
  localparam pos_t P_WALL_XR  = pos_t'(WALL_XR);
  localparam pos_t P_WALL_Y   = pos_t'(WALL_Y);
  localparam pos_t P_SCREEN_W = pos_t'(SCREEN_W);
  localparam pos_t P_ZONE1_L  = pos_t'(ZONE1_L);
  localparam pos_t P_ZONE2_L  = pos_t'(ZONE2_L);
  localparam pos_t P_X_PARK   = pos_t'(X_PARK);
  localparam pos_t P_Y_PARK   = pos_t'(Y_PARK);
  localparam pos_t P_OUT_MAX  = pos_t'((1 << XW) - 1);
  localparam pos_t ZONE_SPAN  = pos_t'(150);
  localparam pos_t DIRECT_LO  = pos_t'(50);
  localparam pos_t DIRECT_HI  = pos_t'(100);

  localparam logic signed [7:0] GRAV = 8'(GRAVITY);
  localparam logic [6:0] HP_START = 7'(HP_INIT);
  localparam logic [6:0] DMG_D    = 7'(DMG_DIRECT);
  localparam logic [6:0] DMG_S    = 7'(DMG_SPLASH);

  localparam logic [1:0] HC_MISS   = 2'd0;
  localparam logic [1:0] HC_SPLASH = 2'd1;
  localparam logic [1:0] HC_DIRECT = 2'd2;
  localparam logic [1:0] HC_WALL   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_FLIGHT, S_RESOLVE, S_OVER} state_t;
  typedef enum logic [1:0] {K_OFF, K_WALL, K_GROUND} kind_t;

  state_t            state_reg, state_next;
  kind_t             kind_reg, kind_next;
  pos_t              x_reg, x_next;
  pos_t              y_reg, y_next;
  logic signed [7:0] vy_reg, vy_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              first_reg, first_next;
  logic              turn_reg, turn_next;
  logic [4:0]        speed_reg, speed_next;
  logic [3:0]        wind_reg, wind_next;
  logic [6:0]        hp1_reg, hp1_next;
  logic [6:0]        hp2_reg, hp2_next;
  logic              end_reg, end_next;
  logic [1:0]        code_reg, code_next;
  logic              over_reg, over_next;

  // Horizontal step never goes backwards: a non-positive speed+wind freezes x.
  logic signed [6:0] step_sum;
  pos_t              step_x;
  assign step_sum = $signed({2'b00, speed_reg}) + $signed({{3{wind_reg[3]}}, wind_reg});
  assign step_x   = (step_sum > 7'sd0) ? pos_t'(step_sum) : P_ZERO;

  logic off_hit, wall_hit, gnd_hit;
  assign off_hit  = (x_reg < P_ZERO) || (x_reg >= P_SCREEN_W);
  assign wall_hit = (x_reg >= P_WALL_XL) && (x_reg <= P_WALL_XR) && (y_reg >= P_WALL_Y);
  assign gnd_hit  = (y_reg >= P_GROUND);

  // Ground hits are scored against the target zone of the player not throwing.
  pos_t       zone_off;
  logic [1:0] ground_code;
  logic [1:0] res_code;
  logic [6:0] dmg;
  logic [6:0] hp_tgt, hp_after;
  logic [6:0] hp1_new, hp2_new;

  assign zone_off = x_reg - (turn_reg ? P_ZONE1_L : P_ZONE2_L);

  always_comb begin
    ground_code = HC_MISS;
    if (zone_off >= DIRECT_LO && zone_off <= DIRECT_HI)
      ground_code = HC_DIRECT;
    else if (zone_off >= P_ZERO && zone_off <= ZONE_SPAN)
      ground_code = HC_SPLASH;
  end

  always_comb begin
    unique case (kind_reg)
      K_WALL:   res_code = HC_WALL;
      K_GROUND: res_code = ground_code;
      default:  res_code = HC_MISS;
    endcase
  end

  assign dmg      = (res_code == HC_DIRECT) ? DMG_D : (res_code == HC_SPLASH) ? DMG_S : 7'd0;
  assign hp_tgt   = turn_reg ? hp1_reg : hp2_reg;
  assign hp_after = (hp_tgt > dmg) ? (hp_tgt - dmg) : 7'd0;
  assign hp1_new  = turn_reg ? hp_after : hp1_reg;
  assign hp2_new  = turn_reg ? hp2_reg : hp_after;

  always_comb begin
    state_next = state_reg;
    kind_next  = kind_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    vy_next    = vy_reg;
    cnt_next   = cnt_reg;
    first_next = first_reg;
    turn_next  = turn_reg;
    speed_next = speed_reg;
    wind_next  = wind_reg;
    hp1_next   = hp1_reg;
    hp2_next   = hp2_reg;
    end_next   = 1'b0;
    code_next  = code_reg;
    over_next  = over_reg;

    unique case (state_reg)
      S_IDLE: begin
        x_next = P_X_PARK;
        y_next = P_Y_PARK;
        if (throw_start) begin
          turn_next  = turn;
          speed_next = speed;
          wind_next  = wind;
          x_next     = turn ? P_X_L2 : P_X_L1;
          y_next     = P_Y_L;
          vy_next    = {2'b00, vy_init};
          cnt_next   = '0;
          first_next = 1'b1;
          state_next = S_FLIGHT;
        end
      end
      S_FLIGHT: begin
        first_next = 1'b0;
        if (!first_reg && (off_hit || wall_hit || gnd_hit)) begin
          kind_next  = off_hit ? K_OFF : (wall_hit ? K_WALL : K_GROUND);
          state_next = S_RESOLVE;
        end else if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          x_next   = turn_reg ? (x_reg - step_x) : (x_reg + step_x);
          y_next   = y_reg - pos_t'(vy_reg);
          vy_next  = vy_reg - GRAV;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_RESOLVE: begin
        end_next  = 1'b1;
        code_next = res_code;
        hp1_next  = hp1_new;
        hp2_next  = hp2_new;
        if (hp1_new == 7'd0 || hp2_new == 7'd0) begin
          over_next  = 1'b1;
          state_next = S_OVER;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_OVER: begin
        x_next = P_X_PARK;
        y_next = P_Y_PARK;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk60MHz or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      kind_reg  <= K_OFF;
      x_reg     <= P_X_PARK;
      y_reg     <= P_Y_PARK;
      vy_reg    <= '0;
      cnt_reg   <= '0;
      first_reg <= 1'b0;
      turn_reg  <= 1'b0;
      speed_reg <= '0;
      wind_reg  <= '0;
      hp1_reg   <= HP_START;
      hp2_reg   <= HP_START;
      end_reg   <= 1'b0;
      code_reg  <= HC_MISS;
      over_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      kind_reg  <= kind_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      vy_reg    <= vy_next;
      cnt_reg   <= cnt_next;
      first_reg <= first_next;
      turn_reg  <= turn_next;
      speed_reg <= speed_next;
      wind_reg  <= wind_next;
      hp1_reg   <= hp1_next;
      hp2_reg   <= hp2_next;
      end_reg   <= end_next;
      code_reg  <= code_next;
      over_reg  <= over_next;
    end
  end

  function automatic logic [XW-1:0] clamp_out(input pos_t v);
    if (v < P_ZERO)
      return '0;
    else if (v > P_OUT_MAX)
      return '1;
    else
      return v[XW-1:0];
  endfunction

  assign xpos_particle = clamp_out(x_reg);
  assign ypos_particle = clamp_out(y_reg);
  assign hp_player1    = hp1_reg;
  assign hp_player2    = hp2_reg;
  assign busy          = (state_reg == S_FLIGHT) || (state_reg == S_RESOLVE);
  assign end_throw     = end_reg;
  assign hit_code      = code_reg;
  assign game_over     = over_reg;

endmodule

// File: tb/tb_projectile_engine.sv
// Self-checking bench for projectile_engine: directed and randomized throws
// compared against a tick-by-tick ballistic model of the game rules.
module tb_projectile_engine;

  localparam int TD = 4;

  logic        clk60MHz = 1'b0;
  logic        rst;
  logic        throw_start;
  logic        turn;
  logic [4:0]  speed;
  logic [5:0]  vy_init;
  logic [3:0]  wind;
  logic [11:0] xpos_particle;
  logic [11:0] ypos_particle;
  logic [6:0]  hp_player1;
  logic [6:0]  hp_player2;
  logic        busy;
  logic        end_throw;
  logic [1:0]  hit_code;
  logic        game_over;

  projectile_engine #(.TICK_DIV(TD)) dut (
    .clk60MHz      (clk60MHz),
    .rst           (rst),
    .throw_start   (throw_start),
    .turn          (turn),
    .speed         (speed),
    .vy_init       (vy_init),
    .wind          (wind),
    .xpos_particle (xpos_particle),
    .ypos_particle (ypos_particle),
    .hp_player1    (hp_player1),
    .hp_player2    (hp_player2),
    .busy          (busy),
    .end_throw     (end_throw),
    .hit_code      (hit_code),
    .game_over     (game_over)
  );

  always #5 clk60MHz = ~clk60MHz;

  int errors = 0;
  int checks = 0;
  int m_hp1, m_hp2;
  bit m_over;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampv(input int v);
    if (v < 0) return 0;
    if (v > 4095) return 4095;
    return v;
  endfunction

  // Reference flight: evaluate collisions on each position, then advance one tick.
  function automatic void model_fly(input bit t, input int spd, input int vyi, input int wnd,
                                    output int code, output int kind, output int fx, output int fy);
    int x, y, vy, step, off, zl;
    bit done;
    x = t ? 712 : 262;
    y = 420;
    vy = vyi;
    step = spd + wnd;
    if (step < 0) step = 0;
    done = 0;
    code = 0;
    kind = 0;
    for (int k = 0; k < 2000 && !done; k++) begin
      if (x < 0 || x >= 1024) begin
        kind = 0; code = 0; done = 1;
      end else if (x >= 497 && x <= 527 && y >= 384) begin
        kind = 1; code = 3; done = 1;
      end else if (y >= 455) begin
        zl = t ? 112 : 712;
        off = x - zl;
        kind = 2;
        code = (off >= 50 && off <= 100) ? 2 : ((off >= 0 && off <= 150) ? 1 : 0);
        done = 1;
      end else begin
        x = t ? x - step : x + step;
        y = y - vy;
        vy = vy - 1;
      end
    end
    fx = x;
    fy = y;
  endfunction

  task automatic find_ground(input bit t, input int want, output int spd, output int vyi,
                             output int wnd, output bit ok);
    int c, kd, fx, fy;
    ok = 0;
    spd = 0; vyi = 0; wnd = 0;
    for (int i = 0; i < 6000 && !ok; i++) begin
      spd = int'($urandom_range(0, 31));
      vyi = int'($urandom_range(0, 63));
      wnd = int'($urandom_range(0, 15)) - 8;
      model_fly(t, spd, vyi, wnd, c, kd, fx, fy);
      if (kd == 2 && c == want) ok = 1;
    end
  endtask

  task automatic do_throw(input string tag, input bit t, input int spd, input int vyi,
                          input int wnd, input bit poke);
    int c, kd, fx, fy, dmg, n, x0;
    bit seen, moved;
    @(negedge clk60MHz);
    turn = t;
    speed = 5'(spd);
    vy_init = 6'(vyi);
    wind = 4'(wnd);
    throw_start = 1'b1;
    @(negedge clk60MHz);
    throw_start = 1'b0;
    if (m_over) begin
      repeat (3) @(negedge clk60MHz);
      check({tag, "_ign_busy"}, 32'(busy), 0);
      check({tag, "_ign_x"}, 32'(xpos_particle), 1025);
      check({tag, "_ign_hp1"}, 32'(hp_player1), m_hp1);
      check({tag, "_ign_hp2"}, 32'(hp_player2), m_hp2);
      $display("throw %s: ignored (game over)", tag);
      return;
    end
    model_fly(t, spd, vyi, wnd, c, kd, fx, fy);
    dmg = (c == 2) ? 30 : ((c == 1) ? 10 : 0);
    if (t) m_hp1 = (m_hp1 > dmg) ? m_hp1 - dmg : 0;
    else   m_hp2 = (m_hp2 > dmg) ? m_hp2 - dmg : 0;
    if (m_hp1 == 0 || m_hp2 == 0) m_over = 1;
    check({tag, "_busy"}, 32'(busy), 1);
    x0 = t ? 712 : 262;
    seen = 0;
    moved = 0;
    for (n = 0; n < 3000 && !seen; n++) begin
      @(negedge clk60MHz);
      throw_start = 1'b0;
      if (end_throw) begin
        seen = 1;
      end else begin
        if (busy && int'(xpos_particle) != x0) moved = 1;
        if (poke && (n % 50) == 10) throw_start = 1'b1;
      end
    end
    check({tag, "_end_seen"}, 32'(seen), 1);
    if (!seen) return;
    check({tag, "_code"}, 32'(hit_code), c);
    check({tag, "_x"}, 32'(xpos_particle), clampv(fx));
    check({tag, "_y"}, 32'(ypos_particle), clampv(fy));
    check({tag, "_hp1"}, 32'(hp_player1), m_hp1);
    check({tag, "_hp2"}, 32'(hp_player2), m_hp2);
    check({tag, "_over"}, 32'(game_over), 32'(m_over));
    check({tag, "_busy_end"}, 32'(busy), 0);
    if (poke) check({tag, "_x_const"}, 32'(moved), 0);
    @(negedge clk60MHz);
    check({tag, "_end_1cyc"}, 32'(end_throw), 0);
    check({tag, "_park_x"}, 32'(xpos_particle), 1025);
    check({tag, "_park_y"}, 32'(ypos_particle), 768);
    if (poke) begin
      repeat (4) @(negedge clk60MHz);
      check({tag, "_no_queue"}, 32'(busy), 0);
    end
    $display("throw %s: turn=%0d speed=%0d vy=%0d wind=%0d -> code=%0d x=%0d y=%0d hp1=%0d hp2=%0d",
             tag, t, spd, vyi, wnd, hit_code, xpos_particle, ypos_particle, hp_player1, hp_player2);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x"}, 32'(xpos_particle), 1025);
    check({tag, "_y"}, 32'(ypos_particle), 768);
    check({tag, "_hp1"}, 32'(hp_player1), 100);
    check({tag, "_hp2"}, 32'(hp_player2), 100);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_end"}, 32'(end_throw), 0);
    check({tag, "_code"}, 32'(hit_code), 0);
    check({tag, "_over"}, 32'(game_over), 0);
  endtask

  initial begin
    int s, v, w;
    bit ok;
    rst = 1'b1;
    throw_start = 1'b0;
    turn = 1'b0;
    speed = '0;
    vy_init = '0;
    wind = '0;
    m_hp1 = 100;
    m_hp2 = 100;
    m_over = 0;
    repeat (3) @(negedge clk60MHz);
    check_reset_vals("reset");
    rst = 1'b0;

    // Direct hit by P1 at x=787 (zone offset 75).
    do_throw("p1_direct", 0, 15, 16, 0, 0);
    check("p1_direct_hp2_70", 32'(hp_player2), 70);

    // P2 splash at x=120, then a ground miss outside zone 1.
    do_throw("p2_splash", 1, 16, 17, 0, 0);
    check("p2_splash_hp1_90", 32'(hp_player1), 90);
    find_ground(1, 0, s, v, w, ok);
    check("find_p2_miss", 32'(ok), 1);
    if (ok) do_throw("p2_miss", 1, s, v, w, 0);

    // P1 into the wall at x=512.
    do_throw("p1_wall", 0, 25, 8, 0, 0);
    check("p1_wall_code", 32'(hit_code), 3);

    // speed+wind negative: vertical-only flight, throw_start pokes ignored.
    do_throw("p1_vertical", 0, 2, 5, -5, 1);

    for (int i = 0; i < 6; i++) begin
      do_throw($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
               int'($urandom_range(0, 15)) - 8, 0);
    end

    // Fresh game, then async reset mid-flight.
    @(negedge clk60MHz);
    rst = 1'b1;
    @(negedge clk60MHz);
    rst = 1'b0;
    m_hp1 = 100; m_hp2 = 100; m_over = 0;
    turn = 1'b0; speed = 5'd10; vy_init = 6'd30; wind = 4'd0;
    throw_start = 1'b1;
    @(negedge clk60MHz);
    throw_start = 1'b0;
    repeat (20) @(negedge clk60MHz);
    check("midflight_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    @(negedge clk60MHz);
    check("async_rst_no_end", 32'(end_throw), 0);
    rst = 1'b0;
    $display("async reset mid-flight: x=%0d y=%0d busy=%0d", xpos_particle, ypos_particle, busy);

    // Drive P2 to 20 HP, then a direct hit saturates at 0 and ends the game.
    do_throw("go_d1", 0, 15, 16, 0, 0);
    do_throw("go_d2", 0, 15, 16, 0, 0);
    find_ground(0, 1, s, v, w, ok);
    check("find_p1_splash", 32'(ok), 1);
    if (ok) begin
      do_throw("go_s1", 0, s, v, w, 0);
      do_throw("go_s2", 0, s, v, w, 0);
    end
    check("go_hp2_20", 32'(hp_player2), 20);
    do_throw("go_final", 0, 15, 16, 0, 0);
    check("go_hp2_0", 32'(hp_player2), 0);
    check("go_over", 32'(game_over), 1);
    do_throw("go_after", 0, 15, 16, 0, 0);
    check("go_over_sticky", 32'(game_over), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
